// File: rtl/keypad_scanner_if.sv
// rtl/keypad_scanner_if.sv - keypad scanner signal bundle
//
// Purpose: groups the keypad matrix pins and the key-code handshake of
// keypad_scanner into one interface.
// Signals:
//   keyRow     [3:0] keypad rows, active-low, asynchronous to CLK
//   keyCol     [3:0] column drive, active-low one-hot
//   keyCode    [3:0] accepted key (row*4+col)
//   keyValid         accepted code pending
//   keyAck           consumer acknowledge
//   keyOverrun       a new key overwrote an unacknowledged code
//   keyPressed       accepted key held or release being debounced
// Modports: master = scanner side, slave = keypad/consumer side.

interface keypad_scanner_if;
  logic [3:0] keyRow;
  logic [3:0] keyCol;
  logic [3:0] keyCode;
  logic       keyValid;
  logic       keyAck;
  logic       keyOverrun;
  logic       keyPressed;

  modport master (
    input  keyRow, keyAck,
    output keyCol, keyCode, keyValid, keyOverrun, keyPressed
  );

  modport slave (
    output keyRow, keyAck,
    input  keyCol, keyCode, keyValid, keyOverrun, keyPressed
  );
endinterface

// File: rtl/keypad_scanner.sv
// rtl/keypad_scanner.sv - 4x4 matrix keypad scanner with debounce and valid/ack
//
// Purpose: drives the keypad columns one at a time, detects a pressed key,
// debounces press and release, and hands one key code per press to the
// consumer through keyValid/keyAck.
// Ports:
//   CLK  board clock
//   RST  synchronous active-high reset
//   kp   keypad_scanner_if.master (rows/ack in; columns, code, valid,
//        overrun, pressed out)
// Parameters:
//   SCAN_DIV      cycles each column is driven while scanning (>=4)
//   DEBOUNCE_CNT  consecutive stable cycles to accept a press/release (>=2)

module keypad_scanner #(
  parameter int SCAN_DIV     = 1000,
  parameter int DEBOUNCE_CNT = 20000
) (
  input logic              CLK,
  input logic              RST,
  keypad_scanner_if.master kp
);

  localparam int DW = $clog2(SCAN_DIV);
  localparam int BW = $clog2(DEBOUNCE_CNT);
  localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
  localparam logic [BW-1:0] DEB_LAST   = BW'(DEBOUNCE_CNT - 1);

  typedef enum logic [1:0] {SCAN, DEBOUNCE, HOLD, RELEASE} state_t;

  state_t        state, state_nxt;
  logic [3:0]    row_s1, row_s2;
  logic [3:0]    cap, cap_nxt;
  logic [1:0]    col, col_nxt;
  logic [1:0]    krow, krow_nxt;
  logic [DW-1:0] dwell, dwell_nxt;
  logic [BW-1:0] deb, deb_nxt;
  logic          accept;
  logic [3:0]    code_q;
  logic          valid_q;
  logic          ovr_q;
  logic [3:0]    rows;

  assign rows = row_s2;

  // Lowest-numbered low row wins when several rows are pulled down.
  function automatic logic [1:0] low_row(input logic [3:0] r);
    if (!r[0])      return 2'd0;
    else if (!r[1]) return 2'd1;
    else if (!r[2]) return 2'd2;
    else            return 2'd3;
  endfunction

  // State register plus datapath registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state   <= SCAN;
      row_s1  <= 4'hF;
      row_s2  <= 4'hF;
      cap     <= 4'hF;
      col     <= 2'd0;
      krow    <= 2'd0;
      dwell   <= '0;
      deb     <= '0;
      code_q  <= 4'd0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state  <= state_nxt;
      row_s1 <= kp.keyRow;
      row_s2 <= row_s1;
      cap    <= cap_nxt;
      col    <= col_nxt;
      krow   <= krow_nxt;
      dwell  <= dwell_nxt;
      deb    <= deb_nxt;
      // A same-cycle ack loses to the new key; the overrun flag records
      // whether the previous code was still unconsumed.
      if (accept) begin
        code_q  <= {krow, col};
        valid_q <= 1'b1;
        ovr_q   <= valid_q & ~kp.keyAck;
      end else if (kp.keyAck && valid_q) begin
        valid_q <= 1'b0;
        ovr_q   <= 1'b0;
      end
    end
  end

  // Next-state and counter logic.
  always_comb begin
    state_nxt = state;
    cap_nxt   = cap;
    col_nxt   = col;
    krow_nxt  = krow;
    dwell_nxt = dwell;
    deb_nxt   = deb;
    accept    = 1'b0;
    case (state)
      SCAN: begin
        // Rows are only trusted at the end of the dwell, once the
        // synchronizer has caught up with the new column.
        if (dwell == DWELL_LAST) begin
          dwell_nxt = '0;
          if (rows == 4'hF) begin
            col_nxt = col + 2'd1;
          end else begin
            cap_nxt   = rows;
            krow_nxt  = low_row(rows);
            deb_nxt   = '0;
            state_nxt = DEBOUNCE;
          end
        end else begin
          dwell_nxt = dwell + DW'(1);
        end
      end
      DEBOUNCE: begin
        if (rows != cap) begin
          col_nxt   = col + 2'd1;
          dwell_nxt = '0;
          state_nxt = SCAN;
        end else if (deb == DEB_LAST) begin
          accept    = 1'b1;
          state_nxt = HOLD;
        end else begin
          deb_nxt = deb + BW'(1);
        end
      end
      HOLD: begin
        if (rows == 4'hF) begin
          deb_nxt   = '0;
          state_nxt = RELEASE;
        end
      end
      RELEASE: begin
        if (rows != 4'hF) begin
          deb_nxt = '0;
        end else if (deb == DEB_LAST) begin
          col_nxt   = col + 2'd1;
          dwell_nxt = '0;
          state_nxt = SCAN;
        end else begin
          deb_nxt = deb + BW'(1);
        end
      end
      default: state_nxt = SCAN;
    endcase
  end

  // Outputs.
  always_comb begin
    kp.keyCol     = ~(4'b0001 << col);
    kp.keyPressed = (state == HOLD) || (state == RELEASE);
    kp.keyCode    = code_q;
    kp.keyValid   = valid_q;
    kp.keyOverrun = ovr_q;
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// tb/tb_keypad_scanner.sv - directed self-checking bench for keypad_scanner
//
// Purpose: models a 4x4 keypad (mask of held keys, optional bounce) and
// checks scanning, debounce, handshake, overrun, row priority and reset.
// Ports: none (top-level bench).

module tb_keypad_scanner;

  logic        CLK;
  logic        RST;
  logic [15:0] mask;
  logic        bounce;
  int          n_checks;
  int          n_errors;

  keypad_scanner_if kp ();

  keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE_CNT(8)) dut (
    .CLK (CLK),
    .RST (RST),
    .kp  (kp.master)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Keypad model: a held key at (r,c) pulls row r low while column c is driven.
  always_comb begin
    kp.keyRow = 4'hF;
    if (!bounce) begin
      for (int r = 0; r < 4; r++) begin
        for (int c = 0; c < 4; c++) begin
          if (mask[r*4+c] && !kp.keyCol[c]) kp.keyRow[r] = 1'b0;
        end
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic wait_pressed(input string tag, input int max);
    for (int i = 0; i < max; i++) begin
      if (kp.keyPressed) break;
      tick();
    end
    check(tag, kp.keyPressed, 1);
  endtask

  task automatic wait_released(input string tag, input int max);
    for (int i = 0; i < max; i++) begin
      if (!kp.keyPressed) break;
      tick();
    end
    check(tag, kp.keyPressed, 0);
  endtask

  task automatic ack_pulse();
    kp.keyAck = 1'b1;
    tick();
    kp.keyAck = 1'b0;
  endtask

  initial begin
    int n;
    n_checks  = 0;
    n_errors  = 0;
    mask      = 16'h0;
    bounce    = 1'b0;
    kp.keyAck = 1'b0;
    RST       = 1'b1;
    tick();
    tick();
    RST = 1'b0;

    // Reset values
    check("rst_col", kp.keyCol, 4'b1110);
    check("rst_valid", kp.keyValid, 0);
    check("rst_code", kp.keyCode, 0);
    check("rst_ovr", kp.keyOverrun, 0);
    check("rst_pressed", kp.keyPressed, 0);

    // 1: idle scan, column every 4 cycles
    repeat (4) tick();
    check("scan_c1", kp.keyCol, 4'b1101);
    repeat (4) tick();
    check("scan_c2", kp.keyCol, 4'b1011);
    repeat (4) tick();
    check("scan_c3", kp.keyCol, 4'b0111);
    repeat (4) tick();
    check("scan_c0", kp.keyCol, 4'b1110);
    check("scan_valid", kp.keyValid, 0);

    // 2: key 9 (row 2, col 1); DEBOUNCE entered 8 edges in, accept 8 later
    mask = 16'h1 << 9;
    repeat (15) tick();
    check("t2_not_yet", kp.keyValid, 0);
    tick();
    check("t2_valid", kp.keyValid, 1);
    check("t2_code", kp.keyCode, 9);
    check("t2_pressed", kp.keyPressed, 1);
    check("t2_col_hold", kp.keyCol, 4'b1101);
    ack_pulse();
    check("t2_ack", kp.keyValid, 0);
    mask = 16'h0;
    repeat (10) tick();
    check("t2_rel_busy", kp.keyPressed, 1);
    tick();
    check("t2_released", kp.keyPressed, 0);
    check("t2_next_col", kp.keyCol, 4'b1011);

    // 3: key 3 (row 0, col 3) with a one-cycle bounce at debounce count 5
    mask = 16'h1 << 3;
    repeat (11) tick();
    bounce = 1'b1;
    tick();
    bounce = 1'b0;
    tick();
    check("t3_deb_col", kp.keyCol, 4'b0111);
    tick();
    check("t3_abort_col", kp.keyCol, 4'b1110);
    check("t3_abort_valid", kp.keyValid, 0);
    repeat (23) tick();
    check("t3_not_yet", kp.keyValid, 0);
    tick();
    check("t3_valid", kp.keyValid, 1);
    check("t3_code", kp.keyCode, 3);
    ack_pulse();
    n = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (kp.keyValid) n++;
    end
    check("t3_no_repeat", n, 0);

    // 4: overrun, then ack coinciding with accept
    mask = 16'h0;
    wait_released("t4_rel_a", 60);
    mask = 16'h1;
    wait_pressed("t4_press_0", 100);
    check("t4_code0", kp.keyCode, 0);
    check("t4_ovr0", kp.keyOverrun, 0);
    mask = 16'h0;
    wait_released("t4_rel_b", 60);
    mask = 16'h1 << 15;
    wait_pressed("t4_press_15", 100);
    check("t4_code15", kp.keyCode, 15);
    check("t4_valid15", kp.keyValid, 1);
    check("t4_ovr15", kp.keyOverrun, 1);
    mask = 16'h0;
    wait_released("t4_rel_c", 60);
    mask = 16'h1;
    repeat (11) tick();
    check("t4_pre_accept", kp.keyPressed, 0);
    ack_pulse();
    check("t4_ackacc_valid", kp.keyValid, 1);
    check("t4_ackacc_ovr", kp.keyOverrun, 0);
    check("t4_ackacc_code", kp.keyCode, 0);
    ack_pulse();
    check("t4_ack_valid", kp.keyValid, 0);
    ack_pulse();
    check("t4_idle_ack_valid", kp.keyValid, 0);
    check("t4_idle_ack_ovr", kp.keyOverrun, 0);

    // 5: rows 1 and 3 on column 0 -> lowest row wins
    mask = 16'h0;
    wait_released("t5_rel_a", 60);
    mask = (16'h1 << 4) | (16'h1 << 12);
    wait_pressed("t5_press", 100);
    check("t5_code", kp.keyCode, 4);
    ack_pulse();
    mask = 16'h0;
    wait_released("t5_rel_b", 60);

    // 6: reset during HOLD with key still held
    mask = 16'h1 << 9;
    wait_pressed("t6_press", 100);
    check("t6_code_pre", kp.keyCode, 9);
    RST = 1'b1;
    tick();
    RST = 1'b0;
    check("t6_rst_col", kp.keyCol, 4'b1110);
    check("t6_rst_valid", kp.keyValid, 0);
    check("t6_rst_code", kp.keyCode, 0);
    check("t6_rst_ovr", kp.keyOverrun, 0);
    check("t6_rst_pressed", kp.keyPressed, 0);
    wait_pressed("t6_redetect", 100);
    check("t6_valid", kp.keyValid, 1);
    check("t6_code", kp.keyCode, 9);
    check("t6_ovr", kp.keyOverrun, 0);
    ack_pulse();
    n = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (kp.keyValid) n++;
    end
    check("t6_once", n, 0);
    mask = 16'h0;
    wait_released("t6_rel", 60);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
